// File: rtl/apb_master_writer_pkg.sv
// bridge_utils: shared burst, response and writer-state types for the AXI-to-APB write path.
package bridge_utils;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        SKIP,
        DONE
    } apb_wr_state_t;

endpackage

// File: rtl/apb_master_writer_if.sv
// apb_master_writer_if: command, write-beat, completion and APB signals of the burst writer.
interface apb_master_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    localparam int NB = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [3:0]            cmd_len;
    logic [2:0]            cmd_size;
    logic [1:0]            cmd_burst;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_strb;
    logic                  done_valid;
    logic [1:0]            done_resp;
    logic                  done_ready;
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [NB-1:0]         pstrb;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst,
        output cmd_ready,
        input  wr_valid, wr_data, wr_strb,
        output wr_ready,
        output done_valid, done_resp,
        input  done_ready,
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst,
        input  cmd_ready,
        output wr_valid, wr_data, wr_strb,
        input  wr_ready,
        input  done_valid, done_resp,
        output done_ready,
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, pslverr
    );
endinterface

// File: rtl/apb_master_writer_addr_gen.sv
// apb_burst_addr_gen: next beat address and burst legality for FIXED/INCR/WRAP bursts.
module apb_burst_addr_gen
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  legal
);
    localparam int                    LOG_NB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ONE    = 1;

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] bnd;
    logic                  wrap_len_ok;

    assign bytes       = ONE << size;
    assign bnd         = ADDR_WIDTH'({1'b0, len} + 5'd1) << size;
    assign wrap_len_ok = len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15;
    assign legal       = size <= 3'(LOG_NB) && burst != 2'b11 && (burst != BURST_WRAP || wrap_len_ok);
    // INCR aligns to the beat size before stepping; WRAP stays inside the boundary-aligned window
    assign next_addr   = burst == BURST_FIXED ? addr :
                         burst == BURST_INCR  ? (addr & ~(bytes - ONE)) + bytes :
                         (addr & ~(bnd - ONE)) | ((addr + bytes) & (bnd - ONE));
endmodule

// File: rtl/apb_master_writer.sv
// apb_master_writer: turns one latched AXI write burst into APB write transfers, one per beat,
// and returns a single accumulated OKAY/SLVERR completion.
module apb_master_writer
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    apb_master_writer_if.master bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    apb_wr_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [3:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NB-1:0]         strb_q, strb_d;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  legal;
    logic                  last;
    logic                  timeout;

    apb_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_addr_gen (
        .addr     (addr_q),
        .len      (len_q),
        .size     (size_q),
        .burst    (burst_q),
        .next_addr(next_addr),
        .legal    (legal)
    );

    assign last    = beat_q == len_q;
    assign timeout = TIMEOUT_CYCLES != 0 && timer_q == TW'(TIMEOUT_CYCLES - 1) && !bus.pready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        err_d   = err_q;
        timer_d = timer_q;
        data_d  = data_q;
        strb_d  = strb_q;
        unique case (state_q)
            IDLE: if (bus.cmd_valid) begin
                addr_d  = bus.cmd_addr;
                len_d   = bus.cmd_len;
                size_d  = bus.cmd_size;
                burst_d = bus.cmd_burst;
                beat_d  = '0;
                err_d   = 1'b0;
                state_d = WDATA;
            end
            WDATA: if (bus.wr_valid) begin
                data_d = bus.wr_data;
                strb_d = bus.wr_strb;
                if (legal) state_d = SETUP;
                else begin
                    err_d   = 1'b1;
                    beat_d  = last ? beat_q : beat_q + 4'd1;
                    state_d = last ? DONE : SKIP;
                end
            end
            SETUP: begin
                timer_d = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                timer_d = timer_q + 1'b1;
                // a timed-out beat is dropped but the burst still moves on to its next beat
                if (bus.pready || timeout) begin
                    err_d   = err_q | !bus.pready | bus.pslverr;
                    addr_d  = last ? addr_q : next_addr;
                    beat_d  = last ? beat_q : beat_q + 4'd1;
                    state_d = last ? DONE : WDATA;
                end
            end
            SKIP: if (bus.wr_valid) begin
                beat_d  = last ? beat_q : beat_q + 4'd1;
                state_d = last ? DONE : SKIP;
            end
            DONE: if (bus.done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

    assign bus.cmd_ready  = state_q == IDLE;
    assign bus.wr_ready   = state_q == WDATA || state_q == SKIP;
    assign bus.psel       = state_q == SETUP || state_q == ACCESS;
    assign bus.penable    = state_q == ACCESS;
    assign bus.pwrite     = bus.psel;
    assign bus.paddr      = addr_q;
    assign bus.pwdata     = data_q;
    assign bus.pstrb      = strb_q;
    assign bus.done_valid = state_q == DONE;
    assign bus.done_resp  = state_q == DONE && err_q ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_apb_master_writer.sv
// tb_apb_master_writer: directed and randomized bursts against a behavioural address/response model.
module tb_apb_master_writer;
    import bridge_utils::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   c0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    apb_master_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [AW-1:0] mon_addr[$];
    logic [DW-1:0] mon_data[$];
    logic [NB-1:0] mon_strb[$];
    int            acc_cyc[$];
    logic [DW-1:0] exp_data[$];
    logic [NB-1:0] exp_strb[$];
    int            unstable = 0;
    int            acc = 0;
    int            wait_n = 0;
    bit            hang = 0;
    int            err_beat = -1;
    int            base = 0;

    // APB slave model and transfer monitor, both evaluated mid-cycle
    always @(negedge clk) begin
        if (bus.psel && !bus.penable) begin
            mon_addr.push_back(bus.paddr);
            mon_data.push_back(bus.pwdata);
            mon_strb.push_back(bus.pstrb);
            acc_cyc.push_back(0);
        end
        if (bus.psel && bus.penable && mon_addr.size() > 0) begin
            acc++;
            acc_cyc[acc_cyc.size()-1]++;
            if (bus.paddr !== mon_addr[$] || bus.pwdata !== mon_data[$] || bus.pstrb !== mon_strb[$] || bus.pwrite !== 1'b1)
                unstable++;
        end else acc = 0;
        bus.pready  = !hang && bus.psel && bus.penable && acc > wait_n;
        bus.pslverr = bus.pready && (mon_addr.size() - 1 - base == err_beat);
    end

    function automatic bit model_legal(input int len, input int size, input int burst);
        return size <= 2 && burst != 3 && (burst != 2 || len == 1 || len == 3 || len == 7 || len == 15);
    endfunction

    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input int len, input int size,
                                                 input int burst, input int i);
        logic [AW-1:0] bytes, bnd, lo;
        bytes = AW'(1) << size;
        if (i == 0 || burst == 0) return a;
        if (burst == 1) return (a / bytes) * bytes + AW'(i) * bytes;
        bnd = AW'(len + 1) * bytes;
        lo  = (a / bnd) * bnd;
        return lo + ((a - lo) + AW'(i) * bytes) % bnd;
    endfunction

    task automatic send_cmd(input logic [AW-1:0] a, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        bus.cmd_size  = size;
        bus.cmd_burst = burst;
        while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL cmd_handshake: cmd_ready=%0b required 1", bus.cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        c0 = cyc;
    endtask

    task automatic send_beat();
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = $urandom;
        bus.wr_strb  = NB'($urandom);
        exp_data.push_back(bus.wr_data);
        exp_strb.push_back(bus.wr_strb);
        while (!bus.wr_ready && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL beat_handshake: wr_ready=%0b required 1", bus.wr_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic run_burst(input logic [AW-1:0] a, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, output logic [1:0] resp, output int cycles);
        int n = 0;
        base = mon_addr.size();
        exp_data.delete();
        exp_strb.delete();
        send_cmd(a, len, size, burst);
        for (int i = 0; i <= int'(len); i++) send_beat();
        while (!bus.done_valid && n < 200) begin @(negedge clk); n++; end
        total++;
        if (n >= 200) begin bad++; $display("FAIL done_wait: done_valid=%0b required 1", bus.done_valid); end
        cycles = cyc - c0;
        resp   = bus.done_resp;
    endtask

    task automatic ack_done();
        bus.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.done_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({bus.cmd_ready, bus.wr_ready, bus.psel, bus.penable, bus.pwrite, bus.done_valid, bus.done_resp} !== 8'b1000_0000)
            begin bad++; $display("FAIL reset_ctrl: got %b required 10000000",
                {bus.cmd_ready, bus.wr_ready, bus.psel, bus.penable, bus.pwrite, bus.done_valid, bus.done_resp}); end
        total++;
        if (bus.paddr !== '0 || bus.pwdata !== '0 || bus.pstrb !== '0)
            begin bad++; $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h required 0", bus.paddr, bus.pwdata, bus.pstrb); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_directed(input string name, input logic [AW-1:0] want[$], input logic [1:0] want_resp,
                                  input logic [1:0] resp);
        total++;
        if (resp !== want_resp) begin bad++; $display("FAIL %s_resp: got %b required %b", name, resp, want_resp); end
        total++;
        if (mon_addr.size() - base != want.size())
            begin bad++; $display("FAIL %s_count: got %0d required %0d", name, mon_addr.size() - base, want.size()); end
        for (int i = 0; i < want.size() && base + i < mon_addr.size(); i++) begin
            total++;
            if (mon_addr[base+i] !== want[i] || mon_data[base+i] !== exp_data[i] || mon_strb[base+i] !== exp_strb[i])
                begin bad++; $display("FAIL %s_beat%0d: got %h/%h/%h required %h/%h/%h", name, i,
                    mon_addr[base+i], mon_data[base+i], mon_strb[base+i], want[i], exp_data[i], exp_strb[i]); end
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp;
        int         cycles;
        int         u0 = unstable;
        run_burst(32'h100, 4'd3, 3'd2, 2'b01, resp, cycles);
        check_directed("incr", '{32'h100, 32'h104, 32'h108, 32'h10C}, RESP_OKAY, resp);
        total++;
        if (cycles != 12) begin bad++; $display("FAIL incr_cycles: got %0d required 12", cycles); end
        total++;
        if (unstable != u0) begin bad++; $display("FAIL incr_stable: got %0d changes required 0", unstable - u0); end
        ack_done();
    endtask

    task automatic test_wrap_fixed();
        logic [1:0] resp;
        int         cycles;
        run_burst(32'h38, 4'd3, 3'd2, 2'b10, resp, cycles);
        check_directed("wrap", '{32'h38, 32'h3C, 32'h30, 32'h34}, RESP_OKAY, resp);
        ack_done();
        run_burst(32'h20, 4'd2, 3'd2, 2'b00, resp, cycles);
        check_directed("fixed", '{32'h20, 32'h20, 32'h20}, RESP_OKAY, resp);
        ack_done();
    endtask

    task automatic test_slverr_wait();
        logic [1:0] resp;
        int         cycles;
        err_beat = 0;
        run_burst(32'h400, 4'd1, 3'd2, 2'b01, resp, cycles);
        err_beat = -1;
        check_directed("slverr", '{32'h400, 32'h404}, RESP_SLVERR, resp);
        ack_done();
        wait_n = 2;
        run_burst(32'h500, 4'd0, 3'd2, 2'b01, resp, cycles);
        wait_n = 0;
        check_directed("wait", '{32'h500}, RESP_OKAY, resp);
        total++;
        if (acc_cyc[base] != 3) begin bad++; $display("FAIL wait_access: got %0d cycles required 3", acc_cyc[base]); end
        ack_done();
    endtask

    task automatic test_timeout();
        logic [1:0] resp;
        int         cycles;
        hang = 1;
        run_burst(32'h600, 4'd1, 3'd2, 2'b01, resp, cycles);
        hang = 0;
        check_directed("timeout", '{32'h600, 32'h604}, RESP_SLVERR, resp);
        for (int i = 0; i < 2 && base + i < acc_cyc.size(); i++) begin
            total++;
            if (acc_cyc[base+i] != TO)
                begin bad++; $display("FAIL timeout_access%0d: got %0d cycles required %0d", i, acc_cyc[base+i], TO); end
        end
        ack_done();
    endtask

    task automatic test_illegal_hold();
        logic [1:0] resp;
        int         cycles;
        run_burst(32'h700, 4'd2, 3'd3, 2'b01, resp, cycles);
        check_directed("bigsize", '{}, RESP_SLVERR, resp);
        total++;
        if (cycles != 3) begin bad++; $display("FAIL bigsize_cycles: got %0d required 3", cycles); end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.done_valid !== 1'b1 || bus.cmd_ready !== 1'b0)
                begin bad++; $display("FAIL done_hold%0d: done_valid=%b cmd_ready=%b required 1/0", k, bus.done_valid, bus.cmd_ready); end
            @(negedge clk);
        end
        ack_done();
        run_burst(32'h800, 4'd1, 3'd2, 2'b11, resp, cycles);
        check_directed("rsvd", '{}, RESP_SLVERR, resp);
        ack_done();
        run_burst(32'h800, 4'd2, 3'd2, 2'b10, resp, cycles);
        check_directed("wraplen", '{}, RESP_SLVERR, resp);
        ack_done();
    endtask

    task automatic test_async_reset();
        logic [1:0] resp;
        int         cycles;
        int         n = 0;
        hang = 1;
        base = mon_addr.size();
        send_cmd(32'h900, 4'd3, 3'd2, 2'b01);
        send_beat();
        send_beat();
        while (!(bus.psel && bus.penable && mon_addr.size() - base == 2) && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL rst_reach_access: psel=%b penable=%b required 1/1", bus.psel, bus.penable); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.psel, bus.penable, bus.done_valid, bus.cmd_ready} !== 4'b0001)
            begin bad++; $display("FAIL rst_async: psel/penable/done_valid/cmd_ready=%b required 0001",
                {bus.psel, bus.penable, bus.done_valid, bus.cmd_ready}); end
        hang = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_burst(32'hA00, 4'd3, 3'd2, 2'b01, resp, cycles);
        check_directed("post_rst", '{32'hA00, 32'hA04, 32'hA08, 32'hA0C}, RESP_OKAY, resp);
        ack_done();
    endtask

    task automatic test_random();
        logic [1:0]    resp, want_resp;
        logic [AW-1:0] a, want;
        int            cycles, len, size, burst, want_cyc, w;
        bit            lg;
        for (int t = 0; t < 40; t++) begin
            a     = $urandom;
            len   = $urandom_range(0, 15);
            size  = $urandom_range(0, 4) == 0 ? 3 : $urandom_range(0, 2);
            burst = $urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2);
            if (burst == 2 && $urandom_range(0, 1) == 1) len = (1 << $urandom_range(1, 4)) - 1;
            w        = $urandom_range(0, 2);
            err_beat = $urandom_range(0, 3) == 0 ? $urandom_range(0, len) : -1;
            wait_n   = w;
            lg       = model_legal(len, size, burst);
            want_resp = (!lg || err_beat >= 0) ? RESP_SLVERR : RESP_OKAY;
            want_cyc  = lg ? (3 + w) * (len + 1) : len + 1;
            run_burst(a, 4'(len), 3'(size), 2'(burst), resp, cycles);
            total++;
            if (resp !== want_resp) begin bad++; $display("FAIL rnd%0d_resp: got %b required %b", t, resp, want_resp); end
            total++;
            if (cycles != want_cyc) begin bad++; $display("FAIL rnd%0d_cycles: got %0d required %0d", t, cycles, want_cyc); end
            total++;
            if (mon_addr.size() - base != (lg ? len + 1 : 0))
                begin bad++; $display("FAIL rnd%0d_count: got %0d required %0d", t, mon_addr.size() - base, lg ? len + 1 : 0); end
            for (int i = 0; lg && i <= len && base + i < mon_addr.size(); i++) begin
                want = model_addr(a, len, size, burst, i);
                total++;
                if (mon_addr[base+i] !== want || mon_data[base+i] !== exp_data[i] || mon_strb[base+i] !== exp_strb[i])
                    begin bad++; $display("FAIL rnd%0d_beat%0d: got %h/%h/%h required %h/%h/%h", t, i,
                        mon_addr[base+i], mon_data[base+i], mon_strb[base+i], want, exp_data[i], exp_strb[i]); end
            end
            err_beat = -1;
            wait_n   = 0;
            ack_done();
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.cmd_size   = '0;
        bus.cmd_burst  = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.wr_strb    = '0;
        bus.done_ready = 1'b0;
        test_reset();
        test_incr();
        test_wrap_fixed();
        test_slverr_wait();
        test_timeout();
        test_illegal_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within 50000 cycles");
        $fatal(1);
    end
endmodule
